sha256_round_ctrl: RTL and testbench

// - Sequences one SHA-256 compression per 512-bit block.
// - Accepts 16 message words serially and runs 64 rounds, one per cycle.
// - Rounds use the shared Ch/Maj/Sigma datapath; the 16-word message schedule is generated on the fly.
// - Adds the result into the chaining state H and presents the 256-bit digest on a valid/ready output.
// - Sits between the host word stream and the hash result consumer; multi-block messages chain via init=0.

---
 rtl/sha256_pkg.sv | 52 +++++
 rtl/func_ch.sv | 10 +
 rtl/sha256_round.sv | 35 +++
 rtl/sha256_round_ctrl.sv | 142 ++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants K, initial hash value IV,
// controller state encoding and the Sigma / sigma / Maj helper functions.
// No ports; imported by sha256_round and sha256_round_ctrl.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    // {H0..H7}, H0 in the top word.
    localparam logic [255:0] SHA_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] SHA_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [31:0] S0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] S1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] Maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/func_ch.sv
// SHA-256 choose function: each result bit takes y where x is 1, else z.
// Ports: x_i, y_i, z_i (32-bit operands), ch_o (32-bit result).
module func_ch (
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    input  logic [31:0] z_i,
    output logic [31:0] ch_o
);
    assign ch_o = (x_i & y_i) ^ (~x_i & z_i);
endmodule

// File: rtl/sha256_round.sv
// One combinational SHA-256 round.
// Ports: v_i working variables {a..h} (a in the top word), w_i message word W_t,
//        k_i round constant K_t, v_o next working variables {a..h}.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [0:7][31:0] v_i,
    input  logic [31:0]      w_i,
    input  logic [31:0]      k_i,
    output logic [0:7][31:0] v_o
);
    logic [31:0] ch;
    logic [31:0] t1;
    logic [31:0] t2;

    func_ch u_ch (
        .x_i  (v_i[4]),
        .y_i  (v_i[5]),
        .z_i  (v_i[6]),
        .ch_o (ch)
    );

    always_comb begin
        t1     = v_i[7] + S1(v_i[4]) + ch + k_i + w_i;
        t2     = S0(v_i[0]) + Maj(v_i[0], v_i[1], v_i[2]);
        v_o[0] = t1 + t2;
        v_o[1] = v_i[0];
        v_o[2] = v_i[1];
        v_o[3] = v_i[2];
        v_o[4] = v_i[3] + t1;
        v_o[5] = v_i[4];
        v_o[6] = v_i[5];
        v_o[7] = v_i[6];
    end
endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 block sequencer: loads 16 words, runs NUM_ROUNDS rounds with an
// on-the-fly 16-entry message schedule, folds the result into H and offers
// the digest to a consumer.
// Ports: clk, rst_n (async active-low); init (IV vs chain, sampled with W0);
//        blk_valid/blk_ready/blk_word (word input); dig_valid/dig_ready/digest
//        (result output, {H0..H7}); busy; round_idx (t while in ROUND);
//        dbg_state (current controller state).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds data stable while valid is high and not yet taken;
// ready never depends combinationally on valid.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = 64,
    parameter int RIDX_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [31:0]       blk_word,
    output logic              dig_valid,
    input  logic              dig_ready,
    output logic [255:0]      digest,
    output logic              busy,
    output logic [RIDX_W-1:0] round_idx,
    output logic [2:0]        dbg_state
);
    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [RIDX_W-1:0]   t_q, t_d;
    logic [0:7][31:0]    h_q, h_d;
    logic [0:7][31:0]    v_q, v_d;
    logic [31:0]         ring_q [16];

    logic                ring_we;
    logic [3:0]          ring_addr;
    logic [31:0]         ring_wdata;
    logic                accept;
    logic [3:0]          tl;
    logic [31:0]         w_sched;
    logic [31:0]         w_t;
    logic [0:7][31:0]    v_next;

    // Ring slot t mod 16 holds W[t-16]; the other taps sit at fixed offsets.
    assign tl      = t_q[3:0];
    assign w_sched = s1(ring_q[tl + 4'd14]) + ring_q[tl + 4'd9]
                   + s0(ring_q[tl + 4'd1]) + ring_q[tl];
    assign w_t     = (t_q >= RIDX_W'(16)) ? w_sched : ring_q[tl];

    sha256_round u_round (
        .v_i (v_q),
        .w_i (w_t),
        .k_i (SHA_K[t_q]),
        .v_o (v_next)
    );

    assign blk_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign accept    = blk_valid && blk_ready;
    assign dig_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign round_idx = (state_q == ST_ROUND) ? t_q : '0;
    assign digest    = h_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        t_d        = t_q;
        h_d        = h_q;
        v_d        = v_q;
        ring_we    = 1'b0;
        ring_addr  = cnt_q;
        ring_wdata = blk_word;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    v_d       = init ? SHA_IV : h_q;
                    if (init) h_d = SHA_IV;
                    ring_we   = 1'b1;
                    ring_addr = 4'd0;
                    cnt_d     = 4'd1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    ring_we = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = ST_ROUND;
                        t_d     = '0;
                    end
                end
            end
            ST_ROUND: begin
                v_d        = v_next;
                // Overwrites W[t-16] with W[t]; for t<16 it rewrites the same value.
                ring_we    = 1'b1;
                ring_addr  = tl;
                ring_wdata = w_t;
                if (t_q == RIDX_W'(NUM_ROUNDS - 1)) begin
                    state_d = ST_FINAL;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            ST_FINAL: begin
                for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (dig_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            t_q     <= '0;
            h_q     <= SHA_IV;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            h_q     <= h_d;
        end
    end

    // Datapath storage carries no reset: its contents are rebuilt by every block.
    always_ff @(posedge clk) begin
        v_q <= v_d;
        if (ring_we) ring_q[ring_addr] <= ring_wdata;
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
module tb_sha256_round_ctrl;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam int ROUNDS = 64;

    localparam logic [31:0] TB_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         init;
    logic         blk_valid;
    logic         blk_ready;
    logic [31:0]  blk_word;
    logic         dig_valid;
    logic         dig_ready;
    logic [255:0] digest;
    logic         busy;
    logic [5:0]   round_idx;
    logic [2:0]   dbg_state;

    int errors = 0;
    int checks = 0;
    logic [255:0] model_h;

    sha256_round_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_word  (blk_word),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .digest    (digest),
        .busy      (busy),
        .round_idx (round_idx),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (plain FIPS 180-4 compression) ----------------
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [31:0] blk [16]);
        logic [31:0] w [64];
        logic [31:0] hv [8];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) begin
            hv[i] = hin[255-32*i -: 32];
            v[i]  = hv[i];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TB_K[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        return {hv[0] + v[0], hv[1] + v[1], hv[2] + v[2], hv[3] + v[3],
                hv[4] + v[4], hv[5] + v[5], hv[6] + v[6], hv[7] + v[7]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_block(input logic [31:0] blk [16], input logic init_v, input int max_gap);
        int gap;
        for (int i = 0; i < 16; i++) begin
            gap = 0;
            if (max_gap > 0 && $urandom_range(0, 1) == 1) gap = $urandom_range(1, max_gap);
            repeat (gap) begin
                @(negedge clk);
                blk_valid = 1'b0;
                blk_word  = $urandom;
                init      = 1'($urandom_range(0, 1));
                checks++;
                if (blk_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL blk_ready_gap: word %0d got %b expected 1", i, blk_ready);
                end
            end
            @(negedge clk);
            blk_valid = 1'b1;
            blk_word  = blk[i];
            init      = (i == 0) ? init_v : 1'($urandom_range(0, 1));
            checks++;
            if (blk_ready !== 1'b1) begin
                errors++;
                $display("FAIL blk_ready_beat: word %0d got %b expected 1", i, blk_ready);
            end
            @(posedge clk);
        end
        #1;
        blk_valid = 1'b0;
        init      = 1'b0;
    endtask

    // Called just after the edge that accepted W15; returns just after dig_valid rises.
    task automatic wait_digest();
        int n = 0;
        logic [5:0] exp_idx;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (dig_valid === 1'b1) break;
            exp_idx = (n < ROUNDS) ? 6'(n) : 6'd0;
            checks++;
            if (round_idx !== exp_idx || busy !== 1'b1) begin
                errors++;
                $display("FAIL round_progress: cycle %0d got idx=%0d busy=%b expected idx=%0d busy=1",
                         n, round_idx, busy, exp_idx);
            end
        end
        checks++;
        if (n != ROUNDS + 1) begin
            errors++;
            $display("FAIL latency: got %0d edges expected %0d", n, ROUNDS + 1);
        end
    endtask

    task automatic take_digest(input int hold, input logic hold_vld, output logic [255:0] d);
        logic [255:0] d0;
        d0 = digest;
        repeat (hold) begin
            @(negedge clk);
            dig_ready = 1'b0;
            blk_valid = hold_vld;
            blk_word  = 32'hdeadbeef;
            init      = 1'b0;
            checks++;
            if (dig_valid !== 1'b1 || digest !== d0 || blk_ready !== 1'b0) begin
                errors++;
                $display("FAIL out_hold: got valid=%b ready=%b digest=%h expected valid=1 ready=0 digest=%h",
                         dig_valid, blk_ready, digest, d0);
            end
        end
        @(negedge clk);
        dig_ready = 1'b1;
        @(posedge clk);
        #1;
        dig_ready = 1'b0;
        blk_valid = 1'b0;
        checks++;
        if (dig_valid !== 1'b0 || busy !== 1'b0 || blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake: got valid=%b busy=%b ready=%b expected valid=0 busy=0 ready=1",
                     dig_valid, busy, blk_ready);
        end
        d = d0;
    endtask

    task automatic run_block(input logic [31:0] blk [16], input logic init_v, input int max_gap,
                             input int hold, input logic hold_vld, output logic [255:0] d);
        model_h = ref_compress(init_v ? IV : model_h, blk);
        send_block(blk, init_v, max_gap);
        wait_digest();
        take_digest(hold, hold_vld, d);
        checks++;
        if (d !== model_h) begin
            errors++;
            $display("FAIL digest_model: got %h expected %h", d, model_h);
        end
    endtask

    function automatic void abc_block(output logic [31:0] b [16]);
        for (int i = 0; i < 16; i++) b[i] = 32'h0;
        b[0]  = 32'h61626380;
        b[15] = 32'h00000018;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        checks++;
        if (digest !== IV || dig_valid !== 1'b0 || blk_ready !== 1'b1 || busy !== 1'b0 || round_idx !== 6'd0) begin
            errors++;
            $display("FAIL reset_values: got digest=%h valid=%b ready=%b busy=%b idx=%0d expected IV/0/1/0/0",
                     digest, dig_valid, blk_ready, busy, round_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_h = IV;
    endtask

    task automatic test_abc();
        logic [31:0] b [16];
        logic [255:0] d;
        abc_block(b);
        run_block(b, 1'b1, 0, 0, 1'b0, d);
        checks++;
        if (d !== ABC_DIG) begin
            errors++;
            $display("FAIL abc: got %h expected %h", d, ABC_DIG);
        end
    endtask

    task automatic test_empty();
        logic [31:0] b [16];
        logic [255:0] d;
        for (int i = 0; i < 16; i++) b[i] = 32'h0;
        b[0] = 32'h80000000;
        run_block(b, 1'b1, 0, 2, 1'b0, d);
        checks++;
        if (d !== EMPTY_DIG) begin
            errors++;
            $display("FAIL empty: got %h expected %h", d, EMPTY_DIG);
        end
    endtask

    task automatic test_two_block();
        logic [31:0] b1 [16];
        logic [31:0] b2 [16];
        logic [255:0] d;
        b1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        for (int i = 0; i < 16; i++) b2[i] = 32'h0;
        b2[15] = 32'h000001c0;
        run_block(b1, 1'b1, 0, 1, 1'b0, d);
        run_block(b2, 1'b0, 0, 0, 1'b0, d);
        checks++;
        if (d !== TWO_DIG) begin
            errors++;
            $display("FAIL two_block: got %h expected %h", d, TWO_DIG);
        end
    endtask

    task automatic test_gapped();
        logic [31:0] b [16];
        logic [255:0] d;
        abc_block(b);
        run_block(b, 1'b1, 5, 0, 1'b0, d);
        checks++;
        if (d !== ABC_DIG) begin
            errors++;
            $display("FAIL gapped_abc: got %h expected %h", d, ABC_DIG);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] b [16];
        logic [255:0] d;
        abc_block(b);
        run_block(b, 1'b1, 0, 10, 1'b1, d);
        checks++;
        if (d !== ABC_DIG) begin
            errors++;
            $display("FAIL bp_first: got %h expected %h", d, ABC_DIG);
        end
        // Next block starts on the very next cycle; a word swallowed in OUT would corrupt it.
        run_block(b, 1'b1, 0, 0, 1'b0, d);
        checks++;
        if (d !== ABC_DIG) begin
            errors++;
            $display("FAIL bp_second: got %h expected %h", d, ABC_DIG);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] b [16];
        logic [255:0] d;
        int n = 0;
        for (int i = 0; i < 16; i++) b[i] = $urandom;
        send_block(b, 1'b1, 0);
        while (round_idx !== 6'd30 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (round_idx !== 6'd30) begin
            errors++;
            $display("FAIL reach_round30: got idx=%0d expected 30", round_idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || dig_valid !== 1'b0 || blk_ready !== 1'b1 || digest !== IV || round_idx !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b valid=%b ready=%b idx=%0d digest=%h expected 0/0/1/0/IV",
                     busy, dig_valid, blk_ready, round_idx, digest);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_h = IV;
        // Chaining with init=0 proves H went back to IV.
        abc_block(b);
        run_block(b, 1'b0, 0, 0, 1'b0, d);
        checks++;
        if (d !== ABC_DIG) begin
            errors++;
            $display("FAIL abc_after_reset: got %h expected %h", d, ABC_DIG);
        end
    endtask

    task automatic test_random();
        logic [31:0] b [16];
        logic [255:0] d;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) b[i] = $urandom;
            run_block(b, 1'($urandom_range(0, 1)), 3, $urandom_range(0, 3), 1'($urandom_range(0, 1)), d);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        init      = 1'b0;
        blk_valid = 1'b0;
        blk_word  = 32'h0;
        dig_ready = 1'b0;
        model_h   = IV;
        test_reset();
        test_abc();
        test_empty();
        test_two_block();
        test_gapped();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
